btb_update: RTL and testbench

- Write-side controller for the 2-way set-associative branch target buffer.
- Accepts resolved-branch records from execute through a valid/ready handshake and buffers them in a 2-entry queue.
- Performs a read-compare-write on the BTB tag/valid/LRU arrays to install, refresh or invalidate entries.
- Also sequences a full-table invalidate (flush). The lookup side only reads the arrays this block writes.

---
 rtl/btb_pkg.sv | 34 +++
 rtl/btb_upd_fifo.sv | 56 +++++
 rtl/btb_update.sv | 190 +++++++++++++++++++
 tb/tb_btb_update.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared widths, state encoding and record layout for the BTB update path
// Contents: width localparams (TAG_WIDTH derived), PC index/tag slice helpers,
//           update FSM states, queued resolved-branch record.
package btb_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int BRANCH_PC    = 10;
  localparam int OFFSET_WIDTH = 4;
  localparam int INDEX_WIDTH  = 3;
  localparam int TAG_WIDTH    = BRANCH_PC - (OFFSET_WIDTH + INDEX_WIDTH);
  localparam int NUM_SETS     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOOK  = 2'd1,
    ST_WR    = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  typedef struct packed {
    logic [BRANCH_PC-1:0]  pc;
    logic [ADDR_WIDTH-1:0] target;
    logic                  taken;
  } upd_rec_t;

  function automatic logic [INDEX_WIDTH-1:0] pc_index(input logic [BRANCH_PC-1:0] pc);
    return pc[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
  endfunction

  function automatic logic [TAG_WIDTH-1:0] pc_tag(input logic [BRANCH_PC-1:0] pc);
    return pc[BRANCH_PC-1:OFFSET_WIDTH+INDEX_WIDTH];
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - 2-entry queue of resolved-branch records
// Ports: clk, rst_n (async, active-low); i_clear drops all entries;
//        i_push/i_rec enqueue; i_pop dequeues; o_head is the oldest entry;
//        o_full/o_empty reflect registered occupancy.
module btb_upd_fifo
  import btb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_clear,
  input  logic     i_push,
  input  upd_rec_t i_rec,
  input  logic     i_pop,
  output upd_rec_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  upd_rec_t   r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_head  = r_mem[r_rptr];

  // Guard against overflow/underflow so a misbehaving caller cannot corrupt occupancy.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_clear) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wptr] <= i_rec;
  end

endmodule

// File: rtl/btb_update.sv
// rtl/btb_update.sv - BTB write-side controller: queued read-compare-write and full-table flush
// Ports: upd_* record handshake from execute; flush_req/flush_busy invalidate-all;
//        rd_* set read request and returned tag/valid/LRU; wr_* array write port.
module btb_update
  import btb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [BRANCH_PC-1:0]   upd_pc,
  input  logic [ADDR_WIDTH-1:0]  upd_target,
  input  logic                   upd_taken,
  input  logic                   flush_req,
  output logic                   flush_busy,
  output logic                   rd_en,
  output logic [INDEX_WIDTH-1:0] rd_index,
  input  logic [1:0]             rd_valid,
  input  logic [TAG_WIDTH-1:0]   rd_tag0,
  input  logic [TAG_WIDTH-1:0]   rd_tag1,
  input  logic                   rd_lru,
  output logic                   wr_en,
  output logic                   wr_both,
  output logic [INDEX_WIDTH-1:0] wr_index,
  output logic                   wr_way,
  output logic                   wr_valid_bit,
  output logic [TAG_WIDTH-1:0]   wr_tag,
  output logic [ADDR_WIDTH-1:0]  wr_target,
  output logic                   wr_lru_val
);

  state_t r_state;
  state_t w_next;

  logic                   r_flush_pend;
  logic [INDEX_WIDTH-1:0] r_flush_idx;

  logic [INDEX_WIDTH-1:0] r_wr_index;
  logic                   r_wr_way;
  logic                   r_wr_valid;
  logic [TAG_WIDTH-1:0]   r_wr_tag;
  logic [ADDR_WIDTH-1:0]  r_wr_target;
  logic                   r_wr_lru;

  upd_rec_t w_rec;
  upd_rec_t w_head;
  logic     w_full;
  logic     w_empty;
  logic     w_push;
  logic     w_pop;
  logic     w_clear;
  logic     w_flush_seen;

  logic                 w_hit0;
  logic                 w_hit1;
  logic                 w_hit_way;
  logic                 w_victim;
  logic                 w_need_wr;
  logic                 w_way;
  logic                 w_vbit;
  logic                 w_lru;
  logic [TAG_WIDTH-1:0] w_tag;

  assign w_rec = '{pc: upd_pc, target: upd_target, taken: upd_taken};

  // A request that has not yet been latched still blocks new records.
  assign w_flush_seen = flush_req || r_flush_pend;
  assign flush_busy   = (r_state == ST_FLUSH);
  assign upd_ready    = !w_full && !flush_busy && !w_flush_seen;
  assign w_push       = upd_valid && upd_ready;

  btb_upd_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_rec   (w_rec),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rd_index = pc_index(w_head.pc);
  assign w_tag    = pc_tag(w_head.pc);

  // Hit/victim selection on the array data returned during LOOK; way0 wins a double hit.
  always_comb begin
    w_hit0    = rd_valid[0] && (rd_tag0 == w_tag);
    w_hit1    = rd_valid[1] && (rd_tag1 == w_tag);
    w_hit_way = !w_hit0;
    if (!rd_valid[0])      w_victim = 1'b0;
    else if (!rd_valid[1]) w_victim = 1'b1;
    else                   w_victim = rd_lru;

    w_need_wr = 1'b0;
    w_way     = 1'b0;
    w_vbit    = 1'b0;
    w_lru     = 1'b0;
    if (w_head.taken) begin
      w_need_wr = 1'b1;
      w_way     = (w_hit0 || w_hit1) ? w_hit_way : w_victim;
      w_vbit    = 1'b1;
      w_lru     = ~w_way;
    end else if (w_hit0 || w_hit1) begin
      // Invalidated way becomes the next victim.
      w_need_wr = 1'b1;
      w_way     = w_hit_way;
      w_vbit    = 1'b0;
      w_lru     = w_hit_way;
    end
  end

  always_comb begin
    w_next  = r_state;
    rd_en   = 1'b0;
    w_pop   = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_flush_seen) begin
          w_next  = ST_FLUSH;
          w_clear = 1'b1;
        end else if (!w_empty) begin
          rd_en  = 1'b1;
          w_next = ST_LOOK;
        end
      end
      ST_LOOK: begin
        if (w_need_wr) begin
          w_next = ST_WR;
        end else begin
          w_pop  = 1'b1;
          w_next = ST_IDLE;
        end
      end
      ST_WR: begin
        w_pop  = 1'b1;
        w_next = ST_IDLE;
      end
      ST_FLUSH: begin
        if (r_flush_idx == INDEX_WIDTH'(NUM_SETS - 1)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_flush_pend <= 1'b0;
      r_flush_idx  <= '0;
    end else begin
      r_state <= w_next;
      // Entering FLUSH consumes the request; requests during FLUSH are absorbed.
      if (r_state == ST_IDLE && w_next == ST_FLUSH) r_flush_pend <= 1'b0;
      else if (flush_req && r_state != ST_FLUSH)    r_flush_pend <= 1'b1;
      if (r_state == ST_FLUSH) r_flush_idx <= r_flush_idx + 1'b1;
      else                     r_flush_idx <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_index  <= '0;
      r_wr_way    <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_tag    <= '0;
      r_wr_target <= '0;
      r_wr_lru    <= 1'b0;
    end else if (r_state == ST_LOOK) begin
      r_wr_index  <= pc_index(w_head.pc);
      r_wr_way    <= w_way;
      r_wr_valid  <= w_vbit;
      r_wr_tag    <= w_tag;
      r_wr_target <= w_head.target;
      r_wr_lru    <= w_lru;
    end
  end

  assign wr_en        = (r_state == ST_WR) || flush_busy;
  assign wr_both      = flush_busy;
  assign wr_index     = flush_busy ? r_flush_idx : r_wr_index;
  assign wr_way       = flush_busy ? 1'b0 : r_wr_way;
  assign wr_valid_bit = flush_busy ? 1'b0 : r_wr_valid;
  assign wr_tag       = flush_busy ? '0 : r_wr_tag;
  assign wr_target    = flush_busy ? '0 : r_wr_target;
  assign wr_lru_val   = flush_busy ? 1'b0 : r_wr_lru;

endmodule

// File: tb/tb_btb_update.sv
// tb/tb_btb_update.sv - directed self-checking bench for btb_update
module tb_btb_update;
  import btb_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   upd_valid;
  logic                   upd_ready;
  logic [BRANCH_PC-1:0]   upd_pc;
  logic [ADDR_WIDTH-1:0]  upd_target;
  logic                   upd_taken;
  logic                   flush_req;
  logic                   flush_busy;
  logic                   rd_en;
  logic [INDEX_WIDTH-1:0] rd_index;
  logic [1:0]             rd_valid;
  logic [TAG_WIDTH-1:0]   rd_tag0;
  logic [TAG_WIDTH-1:0]   rd_tag1;
  logic                   rd_lru;
  logic                   wr_en;
  logic                   wr_both;
  logic [INDEX_WIDTH-1:0] wr_index;
  logic                   wr_way;
  logic                   wr_valid_bit;
  logic [TAG_WIDTH-1:0]   wr_tag;
  logic [ADDR_WIDTH-1:0]  wr_target;
  logic                   wr_lru_val;

  btb_update dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy),
    .rd_en        (rd_en),
    .rd_index     (rd_index),
    .rd_valid     (rd_valid),
    .rd_tag0      (rd_tag0),
    .rd_tag1      (rd_tag1),
    .rd_lru       (rd_lru),
    .wr_en        (wr_en),
    .wr_both      (wr_both),
    .wr_index     (wr_index),
    .wr_way       (wr_way),
    .wr_valid_bit (wr_valid_bit),
    .wr_tag       (wr_tag),
    .wr_target    (wr_target),
    .wr_lru_val   (wr_lru_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        both;
    logic [2:0]  idx;
    logic        way;
    logic        vb;
    logic [2:0]  tag;
    logic [31:0] tgt;
    logic        lru;
  } wr_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   overlap = 0;
  int   acc_log[$];
  int   rd_log[$];
  int   rd_idx_log[$];
  wr_t  wr_log[$];
  logic rdy_hist  [0:1023];
  logic busy_hist [0:1023];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (cyc < 1024) begin
      rdy_hist[cyc]  = upd_ready;
      busy_hist[cyc] = flush_busy;
    end
    if (upd_valid && upd_ready) acc_log.push_back(cyc);
    if (rd_en) begin
      rd_log.push_back(cyc);
      rd_idx_log.push_back(int'(rd_index));
    end
    if (wr_en) begin
      w.cyc  = cyc;
      w.both = wr_both;
      w.idx  = wr_index;
      w.way  = wr_way;
      w.vb   = wr_valid_bit;
      w.tag  = wr_tag;
      w.tgt  = wr_target;
      w.lru  = wr_lru_val;
      wr_log.push_back(w);
    end
    if (wr_en && rd_en) overlap++;
  end

  function automatic int acc_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : -1000;
  endfunction

  function automatic int rd_at(input int i);
    return (i < rd_log.size()) ? rd_log[i] : -1000;
  endfunction

  task automatic clear_logs();
    acc_log.delete();
    rd_log.delete();
    rd_idx_log.delete();
    wr_log.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_arr(input logic [1:0] v, input logic [2:0] t0, input logic [2:0] t1, input logic l);
    rd_valid = v;
    rd_tag0  = t0;
    rd_tag1  = t1;
    rd_lru   = l;
  endtask

  task automatic push(input logic [9:0] pc, input logic [31:0] tgt, input logic tk);
    int n;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = tk;
    upd_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!upd_ready && n < 30) begin
      n++;
      @(negedge clk);
    end
    if (!upd_ready) check("push_timeout", upd_ready, 1);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic chk_wr(input string t, input int i, input int ecyc, input logic [2:0] idx,
                        input logic way, input logic vb, input logic [2:0] tag,
                        input logic [31:0] tgt, input logic lru);
    if (i >= wr_log.size()) begin
      check({t, "_missing"}, 0, 1);
      return;
    end
    check({t, "_cyc"},  wr_log[i].cyc,  ecyc);
    check({t, "_both"}, wr_log[i].both, 0);
    check({t, "_idx"},  wr_log[i].idx,  idx);
    check({t, "_way"},  wr_log[i].way,  way);
    check({t, "_vb"},   wr_log[i].vb,   vb);
    check({t, "_tag"},  wr_log[i].tag,  tag);
    check({t, "_tgt"},  wr_log[i].tgt,  tgt);
    check({t, "_lru"},  wr_log[i].lru,  lru);
  endtask

  task automatic chk_flush(input int i, input int ecyc, input logic [2:0] idx);
    if (i >= wr_log.size()) begin
      check("flush_missing", 0, 1);
      return;
    end
    check("flush_cyc",  wr_log[i].cyc,  ecyc);
    check("flush_both", wr_log[i].both, 1);
    check("flush_idx",  wr_log[i].idx,  idx);
    check("flush_vb",   wr_log[i].vb,   0);
    check("flush_lru",  wr_log[i].lru,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    int cnt;
    rst_n = 1'b0;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_target = '0;
    upd_taken = 1'b0;
    flush_req = 1'b0;
    set_arr(2'b00, 3'd0, 3'd0, 1'b0);
    idle(3);

    check("rst_ready", upd_ready, 1);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_both", wr_both, 0);
    check("rst_busy", flush_busy, 0);
    check("rst_wr_fields", {wr_index, wr_way, wr_valid_bit, wr_tag, wr_target, wr_lru_val}, 0);
    rst_n = 1'b1;
    idle(2);

    // Taken miss on empty set installs way0.
    clear_logs();
    set_arr(2'b00, 3'd0, 3'd0, 1'b0);
    push(10'h0A0, 32'h8000_0040, 1'b1);
    idle(6);
    check("t1_nacc", acc_log.size(), 1);
    check("t1_nrd", rd_log.size(), 1);
    check("t1_rd_cyc", rd_at(0), acc_at(0) + 1);
    check("t1_rd_idx", (rd_idx_log.size() > 0) ? rd_idx_log[0] : -1, 2);
    check("t1_nwr", wr_log.size(), 1);
    chk_wr("t1", 0, acc_at(0) + 3, 3'd2, 1'b0, 1'b1, 3'd1, 32'h8000_0040, 1'b1);

    // Taken hit on way0 refreshes target.
    clear_logs();
    set_arr(2'b11, 3'd1, 3'd5, 1'b0);
    push(10'h0A0, 32'h8000_0100, 1'b1);
    idle(6);
    check("t2_nwr", wr_log.size(), 1);
    chk_wr("t2", 0, acc_at(0) + 3, 3'd2, 1'b0, 1'b1, 3'd1, 32'h8000_0100, 1'b1);

    // Both ways hit, not taken: way0 wins and is invalidated.
    clear_logs();
    set_arr(2'b11, 3'd1, 3'd1, 1'b1);
    push(10'h0A0, 32'h0000_1234, 1'b0);
    idle(6);
    check("t2b_nwr", wr_log.size(), 1);
    chk_wr("t2b", 0, acc_at(0) + 3, 3'd2, 1'b0, 1'b0, 3'd1, 32'h0000_1234, 1'b0);

    // Taken miss on full set uses LRU victim.
    clear_logs();
    set_arr(2'b11, 3'd3, 3'd4, 1'b1);
    push(10'h0A0, 32'h8000_0200, 1'b1);
    idle(6);
    chk_wr("t3", 0, acc_at(0) + 3, 3'd2, 1'b1, 1'b1, 3'd1, 32'h8000_0200, 1'b0);

    // Taken miss, only way0 valid: way1 is the free victim.
    clear_logs();
    set_arr(2'b01, 3'd3, 3'd0, 1'b0);
    push(10'h3F0, 32'h8000_0300, 1'b1);
    idle(6);
    chk_wr("t3b", 0, acc_at(0) + 3, 3'd7, 1'b1, 1'b1, 3'd7, 32'h8000_0300, 1'b0);

    // Taken miss, way0 invalid: way0 chosen regardless of LRU.
    clear_logs();
    set_arr(2'b10, 3'd0, 3'd3, 1'b1);
    push(10'h0B0, 32'h8000_0350, 1'b1);
    idle(6);
    chk_wr("t3c", 0, acc_at(0) + 3, 3'd3, 1'b0, 1'b1, 3'd1, 32'h8000_0350, 1'b1);

    // Not-taken hit on way1 invalidates it.
    clear_logs();
    set_arr(2'b11, 3'd3, 3'd1, 1'b0);
    push(10'h0A0, 32'h8000_0400, 1'b0);
    idle(6);
    chk_wr("t4a", 0, acc_at(0) + 3, 3'd2, 1'b1, 1'b0, 3'd1, 32'h8000_0400, 1'b1);

    // Not-taken miss writes nothing; next record read two cycles later.
    clear_logs();
    set_arr(2'b11, 3'd3, 3'd4, 1'b0);
    push(10'h0A0, 32'h8000_0450, 1'b0);
    push(10'h0B0, 32'h8000_0500, 1'b1);
    idle(8);
    check("t4b_nrd", rd_log.size(), 2);
    check("t4b_rd_gap", rd_at(1) - rd_at(0), 2);
    check("t4b_rd_idx1", (rd_idx_log.size() > 1) ? rd_idx_log[1] : -1, 3);
    check("t4b_nwr", wr_log.size(), 1);
    chk_wr("t4b", 0, rd_at(1) + 2, 3'd3, 1'b0, 1'b1, 3'd1, 32'h8000_0500, 1'b1);

    // Three back-to-back records: third waits for the first pop.
    clear_logs();
    set_arr(2'b00, 3'd0, 3'd0, 1'b0);
    push(10'h0A0, 32'h8000_1000, 1'b1);
    push(10'h0B0, 32'h8000_2000, 1'b1);
    push(10'h3F0, 32'h8000_3000, 1'b1);
    idle(12);
    a0 = acc_at(0);
    check("t5_nacc", acc_log.size(), 3);
    check("t5_acc1", acc_at(1) - a0, 1);
    check("t5_acc2", acc_at(2) - a0, 4);
    check("t5_nwr", wr_log.size(), 3);
    chk_wr("t5_w0", 0, a0 + 3, 3'd2, 1'b0, 1'b1, 3'd1, 32'h8000_1000, 1'b1);
    chk_wr("t5_w1", 1, a0 + 6, 3'd3, 1'b0, 1'b1, 3'd1, 32'h8000_2000, 1'b1);
    chk_wr("t5_w2", 2, a0 + 9, 3'd7, 1'b0, 1'b1, 3'd7, 32'h8000_3000, 1'b1);

    // Flush requested during LOOK with a second record queued.
    clear_logs();
    set_arr(2'b00, 3'd0, 3'd0, 1'b0);
    push(10'h0A0, 32'h8000_4000, 1'b1);
    push(10'h0B0, 32'h8000_5000, 1'b1);
    flush_req = 1'b1;
    idle(1);
    flush_req = 1'b0;
    idle(20);
    a0 = acc_at(0);
    check("t6_nrd", rd_log.size(), 1);
    check("t6_nwr", wr_log.size(), 9);
    chk_wr("t6_w0", 0, a0 + 3, 3'd2, 1'b0, 1'b1, 3'd1, 32'h8000_4000, 1'b1);
    for (int i = 0; i < 8; i++) chk_flush(1 + i, a0 + 5 + i, 3'(i));
    cnt = 0;
    for (int c = a0; c < a0 + 26; c++) if (c >= 0 && c < 1024 && busy_hist[c]) cnt++;
    check("t6_busy_cycles", cnt, 8);
    check("t6_busy_first", busy_hist[a0 + 5], 1);
    check("t6_busy_after", busy_hist[a0 + 13], 0);
    cnt = 0;
    for (int c = a0 + 2; c <= a0 + 12; c++) if (c >= 0 && c < 1024 && rdy_hist[c]) cnt++;
    check("t6_ready_low", cnt, 0);
    check("t6_ready_back", rdy_hist[a0 + 13], 1);

    // Reset during LOOK aborts without a write.
    clear_logs();
    set_arr(2'b00, 3'd0, 3'd0, 1'b0);
    push(10'h0A0, 32'h8000_6000, 1'b1);
    idle(1);
    rst_n = 1'b0;
    #1;
    check("t7_ready", upd_ready, 1);
    check("t7_wr_en", wr_en, 0);
    check("t7_rd_en", rd_en, 0);
    idle(2);
    rst_n = 1'b1;
    idle(5);
    check("t7_nwr", wr_log.size(), 0);

    check("rd_wr_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
